// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage forwarding select and load-use stall control with a 4-deep producer tag pipeline.
module ex_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       SelFwA,
  output logic [1:0]       SelFwB,
  output logic             stall,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             mr;
  } tag_t;
  tag_t ex_q, mem_q, wb_q, wb2_q, ex_d;
  logic hazard, kill, unused_tags;
  logic [1:0] sel_a_d, sel_b_d;
  function automatic logic hit(tag_t t, logic [REG_W-1:0] rs, logic u);
    return u && t.v && t.we && t.rd == rs && t.rd != '0;
  endfunction
  function automatic logic [1:0] sel(tag_t e, tag_t m, tag_t w, logic [REG_W-1:0] rs, logic u);
    return hit(e, rs, u) ? 2'd1 : hit(m, rs, u) ? 2'd2 : hit(w, rs, u) ? 2'd3 : 2'd0;
  endfunction
  // WB2 only ages producers out; the register file already holds their result.
  assign unused_tags = ^{wb2_q, mem_q.mr, wb_q.mr};
  assign hazard = id_valid && ex_q.mr && (hit(ex_q, id_rs1, id_use_rs1) || hit(ex_q, id_rs2, id_use_rs2));
  assign stall = hazard && !flush && !rst;
  assign kill = stall || flush || !id_valid;
  always_comb begin
    ex_d = kill ? '0 : {1'b1, id_rd, id_reg_write, id_mem_read};
    sel_a_d = kill ? 2'd0 : sel(ex_q, mem_q, wb_q, id_rs1, id_use_rs1);
    sel_b_d = kill ? 2'd0 : sel(ex_q, mem_q, wb_q, id_rs2, id_use_rs2);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      wb2_q <= '0;
      SelFwA <= 2'd0;
      SelFwB <= 2'd0;
      ex_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= ex_q;
      wb_q <= mem_q;
      wb2_q <= wb_q;
      SelFwA <= sel_a_d;
      SelFwB <= sel_b_d;
      ex_valid <= !kill;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed vectors for forwarding selects, load-use stall, flush, saturation and reset.
module tb_ex_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0, id_mem_read = 0, flush = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [1:0] SelFwA, SelFwB;
  logic stall, ex_valid;
  logic [2:0] stall_cnt;
  int checks = 0, errors = 0;
  ex_hazard_ctrl #(.REG_W(5), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .SelFwA(SelFwA), .SelFwB(SelFwB), .stall(stall), .ex_valid(ex_valid), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic we, input logic mr);
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_reg_write = we; id_mem_read = mr;
    #1;
  endtask
  task automatic drain();
    id_valid = 0;
    repeat (4) tick();
  endtask
  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_exv", ex_valid, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_sel", {SelFwA, SelFwB}, 0);
    @(negedge clk); rst = 0;
    tick();
    issue(5, 1, 1, 2, 1, 1, 0); tick();
    issue(6, 5, 1, 1, 1, 1, 0);
    chk("alu_nostall", stall, 0);
    tick();
    chk("alu_selA", SelFwA, 1);
    chk("alu_selB", SelFwB, 0);
    chk("alu_exv", ex_valid, 1);
    drain();
    issue(7, 2, 1, 0, 0, 1, 1); tick();
    issue(8, 2, 1, 7, 1, 1, 0);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_stall2", stall, 0);
    tick();
    chk("lu_selB", SelFwB, 2);
    chk("lu_selA", SelFwA, 0);
    chk("lu_exv", ex_valid, 1);
    drain();
    issue(3, 1, 1, 2, 1, 1, 0); tick();
    issue(10, 0, 0, 0, 0, 1, 0); tick();
    issue(11, 0, 0, 0, 0, 1, 0); tick();
    issue(12, 3, 1, 0, 0, 1, 0); tick();
    chk("wb_selA", SelFwA, 3);
    issue(13, 3, 1, 0, 0, 1, 0); tick();
    chk("wb2_selA", SelFwA, 0);
    drain();
    issue(0, 1, 1, 0, 0, 1, 1); tick();
    issue(14, 0, 1, 0, 1, 1, 0);
    chk("x0_nostall", stall, 0);
    tick();
    chk("x0_sel", {SelFwA, SelFwB}, 0);
    drain();
    issue(7, 2, 1, 0, 0, 1, 1); tick();
    issue(8, 2, 1, 7, 0, 1, 0);
    chk("nouse_nostall", stall, 0);
    tick();
    chk("nouse_selB", SelFwB, 0);
    drain();
    issue(4, 1, 1, 0, 0, 1, 0); tick();
    issue(4, 2, 1, 0, 0, 1, 0); tick();
    issue(15, 4, 1, 4, 1, 1, 0); tick();
    chk("young_selA", SelFwA, 1);
    chk("young_selB", SelFwB, 1);
    drain();
    issue(9, 2, 1, 0, 0, 1, 1); tick();
    issue(16, 9, 1, 0, 0, 1, 0); flush = 1; #1;
    chk("fl_stall", stall, 0);
    tick();
    flush = 0; id_valid = 0; #1;
    chk("fl_exv", ex_valid, 0);
    chk("fl_cnt", stall_cnt, 1);
    drain();
    repeat (6) begin
      issue(7, 2, 1, 0, 0, 1, 1); tick();
      issue(8, 2, 1, 7, 1, 1, 0); tick(); tick();
    end
    chk("sat_full", stall_cnt, 7);
    issue(7, 2, 1, 0, 0, 1, 1); tick();
    issue(8, 2, 1, 7, 1, 1, 0);
    chk("sat_stall", stall, 1);
    tick();
    chk("sat_hold", stall_cnt, 7);
    tick();
    issue(7, 2, 1, 0, 0, 1, 1); tick();
    issue(8, 2, 1, 7, 1, 1, 0);
    chk("rs_pre_stall", stall, 1);
    chk("rs_pre_exv", ex_valid, 1);
    rst = 1; #1;
    chk("rs_stall", stall, 0);
    chk("rs_exv", ex_valid, 0);
    chk("rs_cnt", stall_cnt, 0);
    chk("rs_sel", {SelFwA, SelFwB}, 0);
    rst = 0; #1;
    chk("rs_fresh", stall, 0);
    tick();
    chk("rs_exv_after", ex_valid, 1);
    chk("rs_selB_after", SelFwB, 0);
    chk("rs_cnt_after", stall_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 5: register-index width.
REQ-002 Parameter CNT_W, default 16: stall-statistics counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 id_valid  input  1  decode stage holds a valid instruction.
REQ-006 id_rs1, id_rs2  input  REG_W each  decode-stage source register indices.
REQ-007 id_use_rs1, id_use_rs2  input  1 each  instruction reads rs1 / rs2 from the register file.
REQ-008 id_rd  input  REG_W  decode-stage destination register index.
REQ-009 id_reg_write  input  1  instruction writes id_rd.
REQ-010 id_mem_read  input  1  instruction is a load (result available only from MEM/WB).
REQ-011 flush  input  1  branch redirect; kill the decode-stage instruction.
REQ-012 SelFwA, SelFwB  output  2 each  registered forwarding selects for the EX stage: 0 = register data, 1 = Fw1 (EX/MEM), 2 = Fw2 (MEM/WB), 3 = Fw3 (WB+1).
REQ-013 stall  output  1  combinational; hold fetch/decode this cycle.
REQ-014 ex_valid  output  1  registered; EX stage holds a real instruction (0 = bubble).
REQ-015 stall_cnt  output  CNT_W  registered count of stall cycles, saturating.

Function
REQ-016 Controller SHALL keep a 4-deep tag pipeline EX -> MEM -> WB -> WB2; each tag = {valid, rd, reg_write, mem_read}; all tags advance every cycle, no hold.
REQ-017 Producer match SHALL require: tag valid, reg_write=1, rd == source index, rd != 0, source use flag = 1.
REQ-018 Load-use hazard SHALL exist when id_valid=1 and the EX tag matches rs1 or rs2 (REQ-017) with mem_read=1.
REQ-019 stall SHALL equal load-use hazard AND NOT flush.
REQ-020 On a cycle with stall=1 or flush=1 or id_valid=0, the EX tag SHALL load a bubble (valid=0), ex_valid SHALL be 0 next cycle, SelFwA/SelFwB SHALL be 0 next cycle.
REQ-021 Otherwise the EX tag SHALL load {1, id_rd, id_reg_write, id_mem_read} and ex_valid SHALL be 1 next cycle.
REQ-022 Advancing select per source SHALL be computed from current tags with youngest-first priority: EX match -> 1; else MEM match -> 2; else WB match -> 3; else 0.
REQ-023 A non-load EX-tag match SHALL forward (select 1) without stall; a load match never yields select 1 because it stalls.
REQ-024 After a one-cycle load-use stall the load sits in MEM; re-evaluation SHALL yield select 2; a load two or more slots ahead SHALL never stall.
REQ-025 Matches in WB2 or older SHALL yield select 0 (register file already written).
REQ-026 Source with use flag 0 SHALL yield select 0 and SHALL not cause a stall.
REQ-027 Same rd in multiple stages SHALL select the youngest producer.
REQ-028 Stall duration SHALL be exactly one cycle per load-use pair; second cycle re-evaluates and proceeds.
REQ-029 flush with a simultaneous hazard: flush wins, stall=0, EX gets bubble, stall_cnt unchanged.
REQ-030 stall_cnt SHALL increment by 1 on each cycle with stall=1 and saturate at 2^CNT_W-1.

Reset
REQ-031 rst=1 SHALL immediately clear all tag valid bits, SelFwA=0, SelFwB=0, ex_valid=0, stall_cnt=0; stall SHALL read 0 while rst=1.
REQ-032 Reset asserted mid-stall SHALL discard the stall; first cycle after release treats the decode instruction as fresh.

Verification
REQ-033 add x5 then add x6,x5,x1 back-to-back -> no stall, SelFwA=1, SelFwB=0, ex_valid=1.
REQ-034 lw x7 then add x8,x2,x7 -> stall=1 one cycle, ex_valid=0 next, then SelFwB=2, stall_cnt=1.
REQ-035 add x3 writes; two unrelated instrs; then use x3 in rs1 -> SelFwA=3; a fourth-slot use -> SelFwA=0.
REQ-036 Writes to x0 followed by use of x0 on both sources -> SelFwA=SelFwB=0, no stall.
REQ-037 lw x9 then consumer of x9 with flush=1 same cycle -> stall=0, ex_valid=0 next, stall_cnt unchanged.
REQ-038 Force stall_cnt to 2^CNT_W-1, trigger load-use -> count holds; assert rst during stall -> all outputs 0 immediately.
